// File: rtl/complex_vector_chunk_feeder_pkg.sv
// Shared types and derived constants for the chunk feeder and dot-product stage.
// Holds the FSM state enum, the chunk-count helper and default CH / total.
package complex_vector_chunk_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int NOE_DEF   = 16;
  localparam int UNITS_DEF = 8;

  function automatic int calc_ch(input int noe, input int units);
    return (noe + units - 1) / units;
  endfunction

  localparam int CH    = calc_ch(NOE_DEF, UNITS_DEF);
  localparam int total = CH * UNITS_DEF;

endpackage

// File: rtl/complex_vector_chunk_feeder_if.sv
// Memory read bus and chunk stream bundle of the chunk feeder.
// master: feeder side; slave: memory + consumer side.
interface complex_vector_chunk_feeder_if #(
  parameter int ADDR_W        = 8,
  parameter int element_width = 64,
  parameter int no_of_units   = 8
);
  localparam int DW = element_width * no_of_units;

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata_a;
  logic [DW-1:0]     mem_rdata_b;
  logic              consumer_ready;
  logic              outsider_read_now;
  logic [DW-1:0]     first_row_plus_additional;
  logic [DW-1:0]     vector2;
  logic              last_chunk;

  modport master (
    output mem_re,
    output mem_addr,
    input  mem_rdata_a,
    input  mem_rdata_b,
    input  consumer_ready,
    output outsider_read_now,
    output first_row_plus_additional,
    output vector2,
    output last_chunk
  );

  modport slave (
    input  mem_re,
    input  mem_addr,
    output mem_rdata_a,
    output mem_rdata_b,
    output consumer_ready,
    input  outsider_read_now,
    input  first_row_plus_additional,
    input  vector2,
    input  last_chunk
  );

endinterface

// File: rtl/chunk_skid_fifo.sv
// Two-entry fall-through skid FIFO holding paired A/B chunks.
// Ports: clk, reset, i_push/i_wdata, i_pop, o_valid/o_rdata, o_count.
module chunk_skid_fifo #(
  parameter int W = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_rdata,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_cnt;
  logic         w_empty;
  logic         w_bypass;
  logic         w_wr;
  logic         w_rd;

  assign w_empty = (r_cnt == 2'd0);
  // An empty FIFO presents incoming data the same cycle it arrives.
  assign o_valid = !w_empty || i_push;
  assign o_rdata = w_empty ? i_wdata : r_mem[r_rd];
  assign o_count = r_cnt;

  assign w_bypass = w_empty && i_push && i_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_wr) r_wr <= ~r_wr;
      if (w_rd) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule

// File: rtl/complex_vector_chunk_feeder.sv
// Streams two complex vectors from memory as zero-padded lane chunks.
// Ports: clk, reset, start, base_addr, busy, done, bus (master);
// optional stall_count when FEEDER_STALL_CNT_EN is defined.
module complex_vector_chunk_feeder
  import complex_vector_chunk_feeder_pkg::*;
#(
  parameter int NOE           = 16,
  parameter int element_width = 64,
  parameter int no_of_units   = 8,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_count,
`endif
  complex_vector_chunk_feeder_if.master bus
);

  localparam int N_CH = calc_ch(NOE, no_of_units);
  localparam int CW   = $clog2(N_CH + 1);
  localparam int DW   = element_width * no_of_units;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_iss;
  logic [CW-1:0]     r_oidx;
  logic              r_pend;
  logic [ADDR_W-1:0] r_base;
  logic              w_start_acc;
  logic              w_issue;
  logic              w_pop;
  logic              w_last;
  logic              w_fvalid;
  logic [1:0]        w_cnt;
  logic [2*DW-1:0]   w_fdata;

  chunk_skid_fifo #(.W(2*DW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_pend),
    .i_wdata ({bus.mem_rdata_b, bus.mem_rdata_a}),
    .i_pop   (w_pop),
    .o_valid (w_fvalid),
    .o_rdata (w_fdata),
    .o_count (w_cnt)
  );

  assign w_start_acc = (r_state == IDLE) && start;
  // Cap in-flight reads plus stored chunks at the FIFO depth.
  assign w_issue = (r_state == FETCH) &&
                   (({1'b0, r_pend} + w_cnt) < 2'd2);
  assign w_pop   = w_fvalid && bus.consumer_ready;
  assign w_last  = w_fvalid && (r_oidx == CW'(N_CH - 1));

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    unique case (r_state)
      IDLE:  if (start) w_next = FETCH;
      FETCH: if (w_issue && (r_iss == CW'(N_CH - 1))) w_next = DRAIN;
      DRAIN: if (w_pop && w_last) w_next = DONE;
      DONE: begin
        w_next = IDLE;
        done   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_iss   <= '0;
      r_oidx  <= '0;
      r_pend  <= 1'b0;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_issue;
      if (w_start_acc) begin
        r_iss  <= '0;
        r_oidx <= '0;
        r_base <= base_addr;
      end else begin
        if (w_issue) r_iss <= r_iss + 1'b1;
        if (w_pop) r_oidx <= r_oidx + 1'b1;
      end
    end
  end

  assign busy                  = (r_state != IDLE);
  assign bus.mem_re            = w_issue;
  assign bus.mem_addr          = w_issue ? r_base + ADDR_W'(r_iss) : '0;
  assign bus.outsider_read_now = w_fvalid;
  assign bus.last_chunk        = w_last;

  // Lanes past the vector end read zero whatever memory returned.
  always_comb begin
    bus.first_row_plus_additional = '0;
    bus.vector2                   = '0;
    for (int k = 0; k < no_of_units; k++) begin
      if (w_fvalid && (int'(r_oidx) * no_of_units + k < NOE)) begin
        bus.first_row_plus_additional[k*element_width +: element_width] =
          w_fdata[k*element_width +: element_width];
        bus.vector2[k*element_width +: element_width] =
          w_fdata[DW + k*element_width +: element_width];
      end
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (w_start_acc) begin
      r_stall <= '0;
    end else if (w_fvalid && !bus.consumer_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_count = r_stall;
`endif

endmodule
